// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin arbiter sharing the regfile write port among NUM_REQ writeback sources; optional bypass via WB_BYPASS_EN.
// Latency: one cycle from handshake to ctrl_writeEnable/ctrl_writeReg/data_writeReg; the regfile captures on the following edge.
// Backpressure: one-hot req_ready; none while ctrl_hold or ctrl_reset; the output stage never stalls.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    input  logic                    ctrl_hold,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_reg,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    ctrl_writeEnable,
    output logic [4:0]              ctrl_writeReg,
    output logic [31:0]             data_writeReg,
    input  logic [4:0]              byp_addrA,
    input  logic [4:0]              byp_addrB,
    output logic                    byp_hitA,
    output logic                    byp_hitB,
    output logic [31:0]             byp_data
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic          found;
    logic [PW:0]   scan_idx;
    logic          hs;
    logic [4:0]    sel_reg;
    logic [31:0]   sel_data;
    logic          stage_valid;
    logic [4:0]    stage_reg;
    logic [31:0]   stage_data;

    // Scan requests from rr_ptr upward with wrap; first valid source wins unless held or in reset.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PW+1)'(NUM_REQ);
            end
            if (!found && req_valid[scan_idx[PW-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan_idx[PW-1:0];
            end
        end
        if (ctrl_hold || ctrl_reset) begin
            found = 1'b0;
        end
        req_ready = '0;
        if (found) begin
            req_ready[grant_idx] = 1'b1;
        end
        hs       = found;
        sel_reg  = req_reg[grant_idx*5 +: 5];
        sel_data = req_data[grant_idx*32 +: 32];
    end

    // Pointer moves just past the granted source; holds when nothing transfers.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + PW'(1);
        end
    end

    // Writeback stage: capture the granted write, drain to idle when no handshake occurs.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            stage_valid <= 1'b0;
            stage_reg   <= '0;
            stage_data  <= '0;
        end else begin
            stage_valid <= hs;
            if (hs) begin
                stage_reg  <= sel_reg;
                stage_data <= sel_data;
            end
        end
    end

    // Register 0 writes are accepted but never reach the regfile.
    assign ctrl_writeEnable = stage_valid & (stage_reg != 5'd0);
    assign ctrl_writeReg    = stage_reg;
    assign data_writeReg    = stage_data;

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to read ports one cycle ahead of the regfile.
    assign byp_hitA = stage_valid & (stage_reg != 5'd0) & (stage_reg == byp_addrA);
    assign byp_hitB = stage_valid & (stage_reg != 5'd0) & (stage_reg == byp_addrB);
    assign byp_data = stage_data;
`else
    logic unused_byp;
    assign unused_byp = ^{byp_addrA, byp_addrB};
    assign byp_hitA   = 1'b0;
    assign byp_hitB   = 1'b0;
    assign byp_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: directed bench for regfile_wb_arbiter with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: checks req_ready gating under hold and reset.
module tb_regfile_wb_arbiter;

    logic         clock;
    logic         ctrl_reset;
    logic         ctrl_hold;
    logic [3:0]   req_valid;
    logic [19:0]  req_reg;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         ctrl_writeEnable;
    logic [4:0]   ctrl_writeReg;
    logic [31:0]  data_writeReg;
    logic [4:0]   byp_addrA;
    logic [4:0]   byp_addrB;
    logic         byp_hitA;
    logic         byp_hitB;
    logic [31:0]  byp_data;

    logic [4:0]   rreg [4];
    logic [31:0]  rdat [4];

    int n_chk;
    int n_pass;

    assign req_reg  = {rreg[3], rreg[2], rreg[1], rreg[0]};
    assign req_data = {rdat[3], rdat[2], rdat[1], rdat[0]};

    regfile_wb_arbiter #(.NUM_REQ(4)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_hold        (ctrl_hold),
        .req_valid        (req_valid),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .byp_addrA        (byp_addrA),
        .byp_addrB        (byp_addrB),
        .byp_hitA         (byp_hitA),
        .byp_hitB         (byp_hitB),
        .byp_data         (byp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        ctrl_reset = 1'b1;
        ctrl_hold  = 1'b0;
        req_valid  = 4'b0000;
        byp_addrA  = 5'd0;
        byp_addrB  = 5'd0;
        for (int i = 0; i < 4; i++) begin
            rreg[i] = 5'd0;
            rdat[i] = 32'd0;
        end

        // reset state, requests masked during reset
        cyc();
        req_valid = 4'b1111;
        @(negedge clock);
        chk("rst_ready", {28'd0, req_ready}, 32'h0);
        cyc();
        @(negedge clock);
        chk("rst_we", {31'd0, ctrl_writeEnable}, 32'h0);
        chk("rst_wreg", {27'd0, ctrl_writeReg}, 32'h0);
        chk("rst_wdata", data_writeReg, 32'h0);

        // test 1: single write
        cyc();
        ctrl_reset = 1'b0;
        req_valid  = 4'b0001;
        rreg[0]    = 5'd5;
        rdat[0]    = 32'hDEADBEEF;
        @(negedge clock);
        chk("t1_ready", {28'd0, req_ready}, 32'h1);
        cyc();
        req_valid = 4'b0000;
        @(negedge clock);
        chk("t1_we", {31'd0, ctrl_writeEnable}, 32'h1);
        chk("t1_wreg", {27'd0, ctrl_writeReg}, 32'd5);
        chk("t1_wdata", data_writeReg, 32'hDEADBEEF);
        chk("t1_ready_idle", {28'd0, req_ready}, 32'h0);
        cyc();
        @(negedge clock);
        chk("t1_we_drop", {31'd0, ctrl_writeEnable}, 32'h0);

        // test 2: round robin with all sources valid; reset first so the pointer starts at 0
        cyc();
        ctrl_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rreg[i] = 5'(i + 1);
            rdat[i] = 32'hA000_0000 + 32'(i);
        end
        for (int c = 0; c < 6; c++) begin
            cyc();
            ctrl_reset = 1'b0;
            req_valid  = (c < 5) ? 4'b1111 : 4'b0000;
            @(negedge clock);
            if (c < 5) begin
                chk($sformatf("t2_ready_%0d", c), {28'd0, req_ready}, 32'h1 << (c % 4));
            end
            if (c >= 1) begin
                chk($sformatf("t2_we_%0d", c), {31'd0, ctrl_writeEnable}, 32'h1);
                chk($sformatf("t2_wreg_%0d", c), {27'd0, ctrl_writeReg}, 32'((c - 1) % 4 + 1));
                chk($sformatf("t2_wdata_%0d", c), data_writeReg, 32'hA000_0000 + 32'((c - 1) % 4));
            end
        end

        // test 3: write to register 0 from source 2 (pointer is 1 here)
        cyc();
        req_valid = 4'b0100;
        rreg[2]   = 5'd0;
        rdat[2]   = 32'hFFFFFFFF;
        @(negedge clock);
        chk("t3_ready", {28'd0, req_ready}, 32'h4);
        cyc();
        req_valid = 4'b1111;
        rreg[2]   = 5'd3;
        @(negedge clock);
        chk("t3_we_r0", {31'd0, ctrl_writeEnable}, 32'h0);
        chk("t3_ptr3", {28'd0, req_ready}, 32'h8);
        cyc();
        req_valid = 4'b0010;
        @(negedge clock);
        chk("t3_we_src3", {31'd0, ctrl_writeEnable}, 32'h1);
        chk("t3_wreg_src3", {27'd0, ctrl_writeReg}, 32'd4);
        chk("t3_ready_src1", {28'd0, req_ready}, 32'h2);

        // test 4: hold for three cycles with sources 1 and 3 valid, pointer at 2
        cyc();
        ctrl_hold = 1'b1;
        req_valid = 4'b1010;
        @(negedge clock);
        chk("t4_hold_ready0", {28'd0, req_ready}, 32'h0);
        chk("t4_hold_we0", {31'd0, ctrl_writeEnable}, 32'h1);
        chk("t4_hold_wreg0", {27'd0, ctrl_writeReg}, 32'd2);
        cyc();
        @(negedge clock);
        chk("t4_hold_ready1", {28'd0, req_ready}, 32'h0);
        chk("t4_hold_drain", {31'd0, ctrl_writeEnable}, 32'h0);
        cyc();
        @(negedge clock);
        chk("t4_hold_ready2", {28'd0, req_ready}, 32'h0);
        cyc();
        ctrl_hold = 1'b0;
        @(negedge clock);
        chk("t4_release_src3", {28'd0, req_ready}, 32'h8);
        cyc();
        req_valid = 4'b0010;
        @(negedge clock);
        chk("t4_then_src1", {28'd0, req_ready}, 32'h2);
        chk("t4_wreg_src3", {27'd0, ctrl_writeReg}, 32'd4);
        cyc();
        req_valid = 4'b0000;
        @(negedge clock);
        chk("t4_we_src1", {31'd0, ctrl_writeEnable}, 32'h1);
        chk("t4_wreg_src1", {27'd0, ctrl_writeReg}, 32'd2);

        // test 5: reset right after a grant (pointer at 2, so source 0 wins)
        cyc();
        req_valid = 4'b0001;
        rreg[0]   = 5'd9;
        @(negedge clock);
        chk("t5_ready", {28'd0, req_ready}, 32'h1);
        cyc();
        ctrl_reset = 1'b1;
        req_valid  = 4'b1111;
        @(negedge clock);
        chk("t5_rst_ready", {28'd0, req_ready}, 32'h0);
        chk("t5_we_before", {31'd0, ctrl_writeEnable}, 32'h1);
        chk("t5_wreg_before", {27'd0, ctrl_writeReg}, 32'd9);
        cyc();
        ctrl_reset = 1'b0;
        rreg[0]    = 5'd7;
        rdat[0]    = 32'h12345678;
        @(negedge clock);
        chk("t5_we_after", {31'd0, ctrl_writeEnable}, 32'h0);
        chk("t5_ptr0", {28'd0, req_ready}, 32'h1);

        // test 6: bypass outputs with reg 7 in the stage
        cyc();
        req_valid = 4'b0000;
        byp_addrA = 5'd7;
        byp_addrB = 5'd8;
        @(negedge clock);
        chk("t6_we", {31'd0, ctrl_writeEnable}, 32'h1);
        chk("t6_wreg", {27'd0, ctrl_writeReg}, 32'd7);
        chk("t6_wdata", data_writeReg, 32'h12345678);
`ifdef WB_BYPASS_EN
        chk("t6_hitA", {31'd0, byp_hitA}, 32'h1);
        chk("t6_hitB", {31'd0, byp_hitB}, 32'h0);
        chk("t6_bdata", byp_data, 32'h12345678);
`else
        chk("t6_hitA", {31'd0, byp_hitA}, 32'h0);
        chk("t6_hitB", {31'd0, byp_hitB}, 32'h0);
        chk("t6_bdata", byp_data, 32'h0);
`endif
        cyc();
        @(negedge clock);
        chk("t6_hitA_idle", {31'd0, byp_hitA}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) among NUM_REQ writeback sources, such as the ALU, multdiv and load paths.
- Arbitration: round-robin, one grant per cycle, with a valid/ready handshake per source.
- Output: a registered writeback stage that drives the regfile write port directly.
- Writes to register 0 are accepted and discarded.

Parameters:
NUM_REQ, 4, number of writeback requesters (2..8)

Ports:
clock  input  1  system clock; all state updates on rising edge
ctrl_reset  input  1  synchronous, active-high reset
ctrl_hold  input  1  when high, no new grants issue; the output stage still drains
req_valid  input  NUM_REQ  per-requester write request
req_reg  input  5*NUM_REQ  destination register; slice i = [5i+4:5i]
req_data  input  32*NUM_REQ  write data; slice i = [32i+31:32i]
req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
ctrl_writeEnable  output  1  to regfile write enable
ctrl_writeReg  output  5  to regfile write address
data_writeReg  output  32  to regfile write data
byp_addrA  input  5  bypass compare address A (WB_BYPASS_EN)
byp_addrB  input  5  bypass compare address B (WB_BYPASS_EN)
byp_hitA  output  1  bypass hit A
byp_hitB  output  1  bypass hit B
byp_data  output  32  bypass data

Behaviour:
- Reset (ctrl_reset high at a rising edge):
  - rr_ptr=0; stage_valid=0.
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - req_ready forced to 0 combinationally while ctrl_reset is high.
- Grant logic (combinational):
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready is one-hot or zero; it may depend on req_valid.
  - req_ready=0 when ctrl_hold=1, ctrl_reset=1, or no request is valid.
- Requester rules: a requester must hold req_valid, req_reg and req_data stable until its handshake. Valid must not depend on ready.
- Pointer update: on a handshake with source g, rr_ptr <= (g+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- Fairness: with ctrl_hold low, a continuously valid requester is granted within NUM_REQ cycles.
- Output stage (registered) on a handshake at edge t:
  - stage_reg=req_reg[g], stage_data=req_data[g], stage_valid=1.
  - From t until the next edge: ctrl_writeEnable = stage_valid & (stage_reg != 0).
  - The regfile captures the write at edge t+1.
- Output stage with no handshake: stage_valid <= 0 and ctrl_writeEnable drops.
  - ctrl_writeReg / data_writeReg hold their last values. They are don't-care while ctrl_writeEnable=0.
- Stage never stalls: one write per cycle, so there is no backpressure from the port. Sustained throughput is 1 write/cycle.
- Register 0:
  - The handshake completes normally and the pointer advances.
  - ctrl_writeEnable stays 0 for that entry.
- ctrl_hold:
  - While high: no grants; the pointer holds; the stage drains, so ctrl_writeEnable goes to 0 one cycle after hold rises, unless it was already 0.
  - Hold falling: grants resume the same cycle from the held pointer.
- Reset mid-operation: any entry in the stage is discarded and ctrl_writeEnable=0 after the reset edge. Requests that were valid but not granted are not consumed.
- Simultaneous requests to the same register from different sources: serialised in grant order; the last granted write wins in the regfile.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - byp_hitA = stage_valid & (stage_reg != 0) & (stage_reg == byp_addrA); same for byp_hitB.
  - byp_data = stage_data.
  - Purely combinational from stage registers. Lets read ports see a write one cycle before the regfile captures it.
- Undefined: byp_hitA, byp_hitB and byp_data are tied to 0. The byp_addr inputs are ignored. The ports remain present.

Test Plan:
1. Reset, then req_valid=4'b0001, req_reg[0]=5, req_data[0]=32'hDEADBEEF, one cycle → req_ready=4'b0001 that cycle. Next cycle: ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=DEADBEEF. Following cycle: ctrl_writeEnable=0.
2. All four valid continuously, regs 1..4 → grant order 0,1,2,3,0,… one per cycle. ctrl_writeEnable high every cycle, with ctrl_writeReg sequence 1,2,3,4,1.
3. Source 2 with req_reg=0, data=32'hFFFFFFFF → handshake completes, rr_ptr becomes 3, ctrl_writeEnable stays 0.
4. ctrl_hold=1 for 3 cycles with sources 1 and 3 valid, rr_ptr=2 → no req_ready during hold. First grant after release is source 3, then source 1.
5. Grant at cycle t, ctrl_reset=1 at cycle t+1 → ctrl_writeEnable=0 after the reset edge, rr_ptr=0, req_ready=0 during reset.
6. WB_BYPASS_EN, stage holds reg 7 / 32'h12345678, byp_addrA=7, byp_addrB=8 → byp_hitA=1, byp_hitB=0, byp_data=12345678. Without the macro, all bypass outputs are 0.
